cla_result_fifo: RTL
====================

CLA_RESULT_FIFO -- requirements
Module: cla_result_fifo

Interface
REQ-001 Parameter: DEPTH, 4, number of result entries held; SHALL be a power of two, 2..16.
REQ-002 Port: clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 Port: reset  input  1  reset, asynchronous and active-high.
REQ-004 Port: in_valid  input  1  upstream adder/subtractor result is valid this cycle.
REQ-005 Port: in_ready  output  1  block can accept a result this cycle.
REQ-006 Port: op_sel  input  1  0 selects sum/OF_S; 1 selects diff/OF_D.
REQ-007 Port: sum  input  16  two's-complement a+b from the 16-bit CLA stage.
REQ-008 Port: diff  input  16  two's-complement a-b from the 16-bit CLA stage.
REQ-009 Port: OF_S  input  1  signed overflow of sum.
REQ-010 Port: OF_D  input  1  signed overflow of diff.
REQ-011 Port: LessThan  input  1  signed a<b flag.
REQ-012 Port: out_valid  output  1  head entry present.
REQ-013 Port: out_ready  input  1  downstream accepts head entry.
REQ-014 Port: out_data  output  16  head entry result.
REQ-015 Port: out_ovf  output  1  head entry overflow flag.
REQ-016 Port: out_lt  output  1  head entry LessThan flag.
REQ-017 Port: count  output  clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-018 Port: clr_sticky  input  1  clears sticky_ovf and ovf_cnt.
REQ-019 Port: sticky_ovf  output  1  set once any accepted entry had overflow.
REQ-020 Port: ovf_cnt  output  8  accepted overflowing entries, saturating.

Function
REQ-021 Push SHALL occur when in_valid && in_ready; entry = {LessThan, op_sel ? OF_D : OF_S, op_sel ? diff : sum}, sampled at that edge.
REQ-022 in_ready SHALL be 1 iff count < DEPTH; when full, push SHALL be refused even if a pop occurs in the same cycle (no pass-through).
REQ-023 Pop SHALL occur when out_valid && out_ready; out_valid SHALL be 1 iff count > 0.
REQ-024 FIFO SHALL be show-ahead: out_data/out_ovf/out_lt SHALL reflect head entry combinationally from storage; when empty they SHALL drive 0.
REQ-025 Latency: entry pushed at edge N SHALL appear with out_valid=1 after edge N when FIFO was empty; no empty-bypass path.
REQ-026 Simultaneous push and pop when 0 < count < DEPTH: count SHALL be unchanged, both pointers advance.
REQ-027 Read/write pointers SHALL wrap from DEPTH-1 to 0; order SHALL be strictly first-in first-out.
REQ-028 Pop while empty and push while full SHALL have no effect on any state.
REQ-029 sticky_ovf SHALL be set on the edge a pushed entry has ovf=1; ovf_cnt SHALL increment by 1 on the same edge, saturating at 255.
REQ-030 clr_sticky=1 SHALL clear sticky_ovf and ovf_cnt; if an overflowing push coincides, sticky_ovf SHALL end 1 and ovf_cnt SHALL end 1.
REQ-031 Data path SHALL not modify values: no sign extension, truncation or recomputation of flags.

Reset
REQ-032 reset=1 SHALL immediately, independent of clk, set pointers 0, count 0, out_valid 0, out_data/out_ovf/out_lt 0, sticky_ovf 0, ovf_cnt 0, in_ready 1 (unless reset still asserted, when in_ready SHALL be 0).
REQ-033 Reset mid-operation SHALL discard all stored entries; storage contents need not be cleared.
REQ-034 First push SHALL be accepted on the first rising clk edge after reset deasserts.

Verification
REQ-035 op_sel=1, diff=0x8000, OF_D=1, LessThan=0, one push, out_ready=0 -> next cycle out_valid=1, out_data=0x8000, out_ovf=1, out_lt=0, sticky_ovf=1, ovf_cnt=1, count=1.
REQ-036 op_sel=0, sum=0x0DD0, OF_S=1, LessThan=1 push, then sum=0x1388, OF_S=0, LessThan=0 push; out_ready=1 -> pops in order 0x0DD0/ovf1/lt1 then 0x1388/ovf0/lt0; count returns 0.
REQ-037 DEPTH=4, 5 consecutive pushes with out_ready=0 -> count=4, in_ready=0, 5th value absent; then pop and push in same cycle -> pop occurs, push refused, count=3.
REQ-038 Half-full (count=2), push and pop same cycle for 6 cycles -> count stays 2, pointers wrap, outputs FIFO-ordered.
REQ-039 300 overflowing pushes with continuous pop -> ovf_cnt=255; clr_sticky with coincident overflowing push -> sticky_ovf=1, ovf_cnt=1.
REQ-040 Reset asserted asynchronously mid-cycle with count=3 -> count, out_valid, out_data, sticky_ovf, ovf_cnt 0 before next clk edge.

Source files
------------

// File: rtl/cla_result_fifo.sv
// Show-ahead result FIFO behind the 16-bit CLA adder/subtractor: stores the selected
// result with its overflow and LessThan flags, and tracks a sticky/saturating overflow tally.
module cla_result_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       op_sel,
    input  logic [15:0]                sum,
    input  logic [15:0]                diff,
    input  logic                       OF_S,
    input  logic                       OF_D,
    input  logic                       LessThan,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [15:0]                out_data,
    output logic                       out_ovf,
    output logic                       out_lt,
    output logic [$clog2(DEPTH):0]     count,
    input  logic                       clr_sticky,
    output logic                       sticky_ovf,
    output logic [7:0]                 ovf_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [17:0]   mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          sticky_r;
    logic [7:0]    ovf_cnt_r;

    logic          push_s;
    logic          pop_s;
    logic          ovf_push_s;
    logic [17:0]   entry_s;
    logic [17:0]   head_s;

    // Full blocks pushes regardless of a same-cycle pop; in_ready also drops while reset is held.
    assign in_ready   = !reset && (count_r < CW'(DEPTH));
    assign out_valid  = (count_r != {CW{1'b0}});
    assign push_s     = in_valid && in_ready;
    assign pop_s      = out_valid && out_ready;
    assign entry_s    = {LessThan, (op_sel ? OF_D : OF_S), (op_sel ? diff : sum)};
    assign ovf_push_s = push_s && entry_s[16];
    assign head_s     = mem_r[rd_ptr_r];
    assign count      = count_r;
    assign sticky_ovf = sticky_r;
    assign ovf_cnt    = ovf_cnt_r;

    // Head entry presented combinationally; zeros when nothing is stored.
    always_comb begin
        {out_lt, out_ovf, out_data} = 18'd0;
        if (out_valid) begin
            {out_lt, out_ovf, out_data} = head_s;
        end else begin
            {out_lt, out_ovf, out_data} = 18'd0;
        end
    end

    // Storage array; contents are don't-care once discarded by reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= entry_s;
        end
    end

    // Pointers and occupancy; power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Sticky overflow flag and saturating tally; a clear still counts a coincident overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sticky_r  <= 1'b0;
            ovf_cnt_r <= 8'd0;
        end else if (clr_sticky) begin
            sticky_r  <= ovf_push_s;
            ovf_cnt_r <= ovf_push_s ? 8'd1 : 8'd0;
        end else if (ovf_push_s) begin
            sticky_r  <= 1'b1;
            ovf_cnt_r <= (ovf_cnt_r == 8'd255) ? 8'd255 : ovf_cnt_r + 8'd1;
        end
    end
endmodule
